// File: rtl/fe_reset_sequencer.sv
// rtl/fe_reset_sequencer.sv - quiesces DAQ, runs the ASIC reset engine and owns the shared command line
// Requests (host or periodic) collapse into one pending flag; each sequence waits for a quiet line first.
module fe_reset_sequencer #(
    parameter int QUIET    = 16,
    parameter int TMO_BITS = 20,
    parameter int PER_BITS = 24
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ReqReset,
    input  logic                AutoEn,
    input  logic [PER_BITS-1:0] AutoPeriod,
    input  logic                ClrErr,
    input  logic                BusyDaq,
    input  logic                TrgIn,
    input  logic                CmdDaq,
    input  logic                CmdRst,
    input  logic                RstDone,
    output logic                RstStart,
    output logic                CmdOut,
    output logic                TrgOut,
    output logic                Holdoff,
    output logic                Active,
    output logic                TimeoutErr,
    output logic [15:0]         RstCount
);

    localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_HOLD = 5'b00010,
        S_STRT = 5'b00100,
        S_RUN  = 5'b01000,
        S_DONE = 5'b10000
    } state_e;

    state_e              state_q, state_d;
    logic                pending_q, pending_d;
    logic [QW-1:0]       quiet_q, quiet_d;
    logic [TMO_BITS-1:0] tmo_q, tmo_d;
    logic [PER_BITS-1:0] per_q, per_d;
    logic                cmd_q, cmd_d;
    logic                trg_q, trg_d;
    logic                err_q, err_d;
    logic [15:0]         cnt_q, cnt_d;

    logic line_quiet;
    logic auto_on;
    logic per_expire;
    logic err_set;
    logic rst_path;

    assign line_quiet = !BusyDaq && !CmdDaq;
    assign auto_on    = AutoEn && (AutoPeriod != '0);
    assign rst_path   = (state_q == S_STRT) || (state_q == S_RUN);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            quiet_q   <= '0;
            tmo_q     <= '0;
            per_q     <= '0;
            cmd_q     <= 1'b0;
            trg_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            quiet_q   <= quiet_d;
            tmo_q     <= tmo_d;
            per_q     <= per_d;
            cmd_q     <= cmd_d;
            trg_q     <= trg_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        quiet_d    = '0;
        tmo_d      = tmo_q;
        per_d      = per_q;
        cnt_d      = cnt_q;
        per_expire = 1'b0;
        err_set    = 1'b0;

        // Period only advances while idle; >= keeps a shrunk AutoPeriod from running away.
        if (!auto_on) begin
            per_d = '0;
        end else if (state_q == S_IDLE) begin
            if (per_q >= AutoPeriod - PER_BITS'(1)) begin
                per_d      = '0;
                per_expire = 1'b1;
            end else begin
                per_d = per_q + PER_BITS'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pending_q) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (line_quiet) begin
                    if (quiet_q == QW'(QUIET - 1)) state_d = S_STRT;
                    else                           quiet_d = quiet_q + QW'(1);
                end
            end
            S_STRT: begin
                tmo_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                tmo_d = tmo_q + TMO_BITS'(1);
                if (RstDone) begin
                    state_d = S_DONE;
                end else if (tmo_d == '1) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                cnt_d   = cnt_q + 16'd1;
                per_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pending_d = (state_q == S_STRT) ? 1'b0 : (pending_q | ReqReset | per_expire);
    assign cmd_d     = rst_path ? CmdRst : CmdDaq;
    assign trg_d     = TrgIn && (state_q == S_IDLE);
    assign err_d     = err_set ? 1'b1 : (ClrErr ? 1'b0 : err_q);

    assign RstStart   = (state_q == S_STRT);
    assign Holdoff    = (state_q != S_IDLE);
    assign Active     = (state_q != S_IDLE);
    assign CmdOut     = cmd_q;
    assign TrgOut     = trg_q;
    assign TimeoutErr = err_q;
    assign RstCount   = cnt_q;

endmodule

// File: tb/tb_fe_reset_sequencer.sv
// tb/tb_fe_reset_sequencer.sv - scoreboard bench with a procedural timeline model of the reset sequence
module tb_fe_reset_sequencer;

    localparam int QUIET     = 4;
    localparam int TMO_BITS  = 6;
    localparam int PER_BITS  = 24;
    localparam int TMO_LIMIT = (1 << TMO_BITS) - 1;

    logic                Clock = 1'b0;
    logic                Reset, ReqReset, AutoEn, ClrErr, BusyDaq, TrgIn, CmdDaq, CmdRst, RstDone;
    logic [PER_BITS-1:0] AutoPeriod;
    logic                RstStart, CmdOut, TrgOut, Holdoff, Active, TimeoutErr;
    logic [15:0]         RstCount;

    fe_reset_sequencer #(.QUIET(QUIET), .TMO_BITS(TMO_BITS), .PER_BITS(PER_BITS)) dut (
        .Clock(Clock), .Reset(Reset), .ReqReset(ReqReset), .AutoEn(AutoEn),
        .AutoPeriod(AutoPeriod), .ClrErr(ClrErr), .BusyDaq(BusyDaq), .TrgIn(TrgIn),
        .CmdDaq(CmdDaq), .CmdRst(CmdRst), .RstDone(RstDone), .RstStart(RstStart),
        .CmdOut(CmdOut), .TrgOut(TrgOut), .Holdoff(Holdoff), .Active(Active),
        .TimeoutErr(TimeoutErr), .RstCount(RstCount)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        holdoff;
        logic        active;
        logic        start;
        logic        cmd;
        logic        trg;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    typedef enum {R_IDLE, R_HOLD, R_STRT, R_RUN, R_DONE} region_e;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("holdoff",    Holdoff,    mon_e.holdoff);
            check("active",     Active,     mon_e.active);
            check("rst_start",  RstStart,   mon_e.start);
            check("cmd_out",    CmdOut,     mon_e.cmd);
            check("trg_out",    TrgOut,     mon_e.trg);
            check("timeout",    TimeoutErr, mon_e.err);
            check("rst_count",  RstCount,   mon_e.cnt);
        end
    end

    // Reference model: walks the sequence as a timeline, one clock per step.
    bit          m_pending = 0, m_cmd = 0, m_trg = 0, m_err = 0, m_rst_hit = 0;
    int          m_per = 0;
    logic [15:0] m_cnt = '0;
    bit          s_done, s_quiet;

    task automatic emit(input region_e r);
        exp_t e;
        e.holdoff = (r != R_IDLE);
        e.active  = (r != R_IDLE);
        e.start   = (r == R_STRT);
        e.cmd     = m_cmd;
        e.trg     = m_trg;
        e.err     = m_err;
        e.cnt     = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic step(input region_e r, input bit tmo_cycle);
        bit expire;
        @(posedge Clock);
        s_done  = RstDone;
        s_quiet = !BusyDaq && !CmdDaq;
        if (Reset) begin
            m_pending = 0; m_per = 0; m_cmd = 0; m_trg = 0; m_err = 0; m_cnt = '0;
            m_rst_hit = 1;
            return;
        end
        expire    = (r == R_IDLE) && AutoEn && (AutoPeriod != 0) && (m_per >= int'(AutoPeriod) - 1);
        m_pending = (r == R_STRT) ? 1'b0 : (m_pending | ReqReset | expire);
        if (!AutoEn || AutoPeriod == 0 || r == R_DONE) m_per = 0;
        else if (r == R_IDLE) m_per = expire ? 0 : m_per + 1;
        m_cmd = (r == R_STRT || r == R_RUN) ? CmdRst : CmdDaq;
        m_trg = TrgIn && (r == R_IDLE);
        if (r == R_RUN && tmo_cycle && !s_done) m_err = 1;
        else if (ClrErr)                        m_err = 0;
        if (r == R_DONE) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic run_sequence();
        bit was_pending;
        int run_len;
        int n;
        m_rst_hit = 0;
        do begin
            was_pending = m_pending;
            emit(R_IDLE);
            step(R_IDLE, 0);
            if (m_rst_hit) return;
        end while (!was_pending);
        run_len = 0;
        forever begin
            emit(R_HOLD);
            step(R_HOLD, 0);
            if (m_rst_hit) return;
            run_len = s_quiet ? run_len + 1 : 0;
            if (run_len == QUIET) break;
        end
        emit(R_STRT);
        step(R_STRT, 0);
        if (m_rst_hit) return;
        n = 0;
        forever begin
            emit(R_RUN);
            n++;
            step(R_RUN, n == TMO_LIMIT);
            if (m_rst_hit) return;
            if (s_done) begin
                emit(R_DONE);
                step(R_DONE, 0);
                return;
            end
            if (n == TMO_LIMIT) return;
        end
    endtask

    initial begin
        step(R_IDLE, 0);
        forever run_sequence();
    end

    // Reset-engine stand-in: answers each Start with a Done pulse after resp_dly clocks.
    bit resp_en   = 1;
    int resp_dly  = 3;
    bit trg_const = 0;
    initial begin
        int cd;
        cd = -1;
        RstDone = 0;
        forever begin
            @(negedge Clock);
            RstDone = 0;
            if (cd == 0) begin
                RstDone = 1;
                cd = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (RstStart && resp_en) cd = resp_dly;
        end
    end

    initial begin
        CmdRst = 0;
        TrgIn  = 0;
        forever begin
            @(negedge Clock);
            CmdRst = 1'($urandom_range(0, 1));
            TrgIn  = trg_const ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic pulse_req();
        ReqReset = 1;
        tick(1);
        ReqReset = 0;
    endtask

    task automatic wait_start(input int bound, input string name, output int k);
        k = 0;
        while (!RstStart && k < bound) begin
            tick(1);
            k++;
        end
        check(name, RstStart, 1);
    endtask

    task automatic count_starts(input int n, output int starts);
        starts = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (RstStart) starts++;
        end
    endtask

    initial begin
        int k;
        int starts;
        Reset = 1; ReqReset = 0; AutoEn = 0; AutoPeriod = '0; ClrErr = 0;
        BusyDaq = 0; CmdDaq = 0;
        tick(3);
        Reset = 0;
        tick(3);

        // basic sequence with the DAQ idle
        pulse_req();
        wait_start(20, "basic_start_seen", k);
        check("basic_start_latency", k, 5);
        tick(20);
        check("basic_count", RstCount, 1);

        // busy DAQ then a CmdDaq blip during HOLD
        BusyDaq = 1;
        pulse_req();
        tick(19);
        BusyDaq = 0;
        tick(2);
        CmdDaq = 1;
        tick(1);
        CmdDaq = 0;
        check("cmd_daq_passthru", CmdOut, 1);
        wait_start(20, "busy_start_seen", k);
        check("busy_start_latency", k, 4);
        tick(20);

        // periodic resets
        resp_dly   = 9;
        AutoPeriod = 100;
        AutoEn     = 1;
        count_starts(440, starts);
        check("periodic_starts", starts, 3);
        AutoPeriod = 0;
        count_starts(150, starts);
        check("period_zero_starts", starts, 0);
        AutoEn     = 0;
        AutoPeriod = 100;

        // one and two requests during RUN each give one follow-on
        resp_dly = 8;
        pulse_req();
        wait_start(20, "run_req1_start", k);
        tick(3);
        pulse_req();
        count_starts(100, starts);
        check("run_req1_followon", starts, 1);
        pulse_req();
        wait_start(20, "run_req2_start", k);
        tick(2);
        pulse_req();
        tick(2);
        pulse_req();
        count_starts(100, starts);
        check("run_req2_followon", starts, 1);

        // timeout with Done withheld
        resp_en = 0;
        pulse_req();
        wait_start(20, "tmo_start", k);
        k = 0;
        while (Holdoff && k < 100) begin
            tick(1);
            k++;
        end
        check("timeout_run_len", k, TMO_LIMIT + 1);
        check("timeout_err_set", TimeoutErr, 1);
        tick(5);
        ClrErr = 1;
        tick(1);
        ClrErr = 0;
        check("timeout_err_clr", TimeoutErr, 0);
        resp_en = 1;

        // trigger gating, then Reset in the middle of RUN
        trg_const = 1;
        pulse_req();
        tick(30);
        resp_dly = 20;
        pulse_req();
        wait_start(20, "midrun_start", k);
        tick(3);
        Reset = 1;
        tick(1);
        Reset = 0;
        check("midrun_holdoff", Holdoff, 0);
        check("midrun_cmdout", CmdOut, 0);
        check("midrun_count", RstCount, 0);
        resp_dly = 5;
        pulse_req();
        wait_start(40, "post_reset_start", k);
        tick(40);
        trg_const = 0;

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            BusyDaq  = ($urandom_range(0, 3) == 0);
            CmdDaq   = ($urandom_range(0, 7) == 0);
            ReqReset = ($urandom_range(0, 49) == 0);
            ClrErr   = ($urandom_range(0, 63) == 0);
            Reset    = ($urandom_range(0, 399) == 0);
            if (i % 300 == 0) begin
                AutoEn     = 0;
                AutoPeriod = PER_BITS'($urandom_range(20, 120));
            end else if (i % 300 == 1) begin
                AutoEn = 1'($urandom_range(0, 1));
            end
            if (i % 100 == 50) begin
                resp_dly = $urandom_range(0, 12);
                resp_en  = ($urandom_range(0, 9) != 0);
            end
            tick(1);
        end
        Reset = 0; ReqReset = 0; ClrErr = 0; BusyDaq = 0; CmdDaq = 0; AutoEn = 0;
        resp_en = 1;
        tick(5);
        check("scoreboard_drained", exp_q.size() < 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
